// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES equal segments and
// one segment is resolved per cycle, under a single global valid/ready stall.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             C_out,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;

  generate
    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("pipelined_addsub: illegal WIDTH/STAGES combination");
    end
  endgenerate

  // Rank k holds segments 0..k-1 resolved in s_q[k] and the carry into segment k in c_q[k].
  logic             v_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] bx_q  [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic             c_q   [STAGES];
  logic             sub_q [STAGES];

  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_d   [STAGES];

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;
  logic             advance;

  always_comb begin
    logic [SEG:0] seg_t;
    seg_t = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_t  = {1'b0, a_q[k][k*SEG +: SEG]} + {1'b0, bx_q[k][k*SEG +: SEG]}
             + {{SEG{1'b0}}, c_q[k]};
      s_d[k] = s_q[k];
      s_d[k][k*SEG +: SEG] = seg_t[SEG-1:0];
      c_d[k] = seg_t[SEG];
    end
  end

  // Flags use the inverted B operand, so one overflow rule covers add and subtract.
  always_comb begin
    cout_d = sub_q[STAGES-1] ^ c_d[STAGES-1];
    ovf_d  = (a_q[STAGES-1][WIDTH-1] == bx_q[STAGES-1][WIDTH-1]) &&
             (s_d[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
    zero_d = (s_d[STAGES-1] == '0);
  end

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign SUM       = sum_q;
  assign C_out     = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else if (advance) begin
      v_q[0]   <= in_valid;
      a_q[0]   <= A;
      bx_q[0]  <= sub ? ~B : B;
      s_q[0]   <= '0;
      c_q[0]   <= sub ? ~C_in : C_in;
      sub_q[0] <= sub;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]   <= v_q[k-1];
        a_q[k]   <= a_q[k-1];
        bx_q[k]  <= bx_q[k-1];
        s_q[k]   <= s_d[k-1];
        c_q[k]   <= c_d[k-1];
        sub_q[k] <= sub_q[k-1];
      end
      out_valid_q <= v_q[STAGES-1];
      // Bubbles leave the last result and flags on the outputs.
      if (v_q[STAGES-1]) begin
        sum_q  <= s_d[STAGES-1];
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three instances (8/2, 32/4, 32/1) share random stimulus and
// are checked every cycle against an arithmetic reference model with per-op age tracking.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [31:0] sum;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  typedef struct {
    int   age;
    res_t r;
  } entry_t;

  localparam int ST [3] = '{2, 4, 1};
  localparam int W  [3] = '{8, 32, 32};

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        C_in = 1'b0;
  logic        sub = 1'b0;

  logic        dov  [3];
  logic        dir  [3];
  logic        dc   [3];
  logic        dovf [3];
  logic        dz   [3];
  logic [31:0] dsum [3];
  logic [7:0]  sum8;

  int errors = 0;
  int checks = 0;

  entry_t sbq  [3][$];
  res_t   last [3];

  always #5 Clock = ~Clock;

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_d0 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(dir[0]),
    .A(A[7:0]), .B(B[7:0]), .C_in(C_in), .sub(sub),
    .out_valid(dov[0]), .out_ready(out_ready), .SUM(sum8),
    .C_out(dc[0]), .overflow(dovf[0]), .zero(dz[0]));
  assign dsum[0] = {24'd0, sum8};

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_d1 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(dir[1]),
    .A(A), .B(B), .C_in(C_in), .sub(sub),
    .out_valid(dov[1]), .out_ready(out_ready), .SUM(dsum[1]),
    .C_out(dc[1]), .overflow(dovf[1]), .zero(dz[1]));

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_d2 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(dir[2]),
    .A(A), .B(B), .C_in(C_in), .sub(sub),
    .out_valid(dov[2]), .out_ready(out_ready), .SUM(dsum[2]),
    .C_out(dc[2]), .overflow(dovf[2]), .zero(dz[2]));

  // Plain integer arithmetic: unsigned result for SUM/carry, signed result for overflow.
  function automatic res_t ref_op(input longint a_in, input longint b_in,
                                  input bit cin, input bit sb, input int w);
    longint m, a, b, ci, full, sa, sbv, sres;
    res_t   r;
    m    = longint'(1) << w;
    a    = a_in & (m - 1);
    b    = b_in & (m - 1);
    ci   = cin ? 64'sd1 : 64'sd0;
    full = sb ? (a - b - ci) : (a + b + ci);
    r.sum = 32'(full & (m - 1));
    r.c   = sb ? (full < 0) : (full >= m);
    sa    = (a >= m / 2) ? a - m : a;
    sbv   = (b >= m / 2) ? b - m : b;
    sres  = sb ? (sa - sbv - ci) : (sa + sbv + ci);
    r.o   = (sres < -(m / 2)) || (sres >= m / 2);
    r.z   = (r.sum == 32'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference pipeline: an op is visible once it has seen ST advancing edges.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int d = 0; d < 3; d++) begin
        sbq[d].delete();
        last[d] = '0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        bit     hv;
        entry_t e;
        hv = (sbq[d].size() > 0) && (sbq[d][0].age == ST[d]);
        if (!hv || out_ready) begin
          if (hv) begin
            last[d] = sbq[d][0].r;
            void'(sbq[d].pop_front());
          end
          for (int i = 0; i < sbq[d].size(); i++) sbq[d][i].age = sbq[d][i].age + 1;
          if (in_valid) begin
            e.age = 0;
            e.r   = ref_op({32'd0, A}, {32'd0, B}, C_in, sub, W[d]);
            sbq[d].push_back(e);
          end
        end
      end
    end
  end

  always @(negedge Clock) begin
    for (int d = 0; d < 3; d++) begin
      bit   hv;
      res_t ex;
      hv = (sbq[d].size() > 0) && (sbq[d][0].age == ST[d]);
      ex = hv ? sbq[d][0].r : last[d];
      chk($sformatf("d%0d out_valid", d), {31'd0, dov[d]}, {31'd0, hv});
      chk($sformatf("d%0d in_ready", d), {31'd0, dir[d]}, {31'd0, (!hv || out_ready)});
      chk($sformatf("d%0d SUM", d), dsum[d], ex.sum);
      chk($sformatf("d%0d flags", d), {29'd0, dc[d], dovf[d], dz[d]}, {29'd0, ex.c, ex.o, ex.z});
    end
  end

  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input bit c, input bit s, input bit r);
    in_valid  = v;
    A         = a;
    B         = b;
    C_in      = c;
    sub       = s;
    out_ready = r;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0080;
      5: return 32'h0000_007F;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    res_t p;
    int   cnt;

    p = ref_op(64'hFF, 64'h01, 1'b0, 1'b0, 8);
    chk("model ff+1", {p.sum, p.c, p.o, p.z}, {32'h00, 1'b1, 1'b0, 1'b1});
    p = ref_op(64'h7F, 64'h01, 1'b0, 1'b0, 8);
    chk("model 7f+1", {p.sum, p.c, p.o, p.z}, {32'h80, 1'b0, 1'b1, 1'b0});
    p = ref_op(64'h00, 64'h01, 1'b0, 1'b1, 8);
    chk("model 0-1", {p.sum, p.c, p.o, p.z}, {32'hFF, 1'b1, 1'b0, 1'b0});
    p = ref_op(64'h80, 64'h01, 1'b0, 1'b1, 8);
    chk("model 80-1", {p.sum, p.c, p.o, p.z}, {32'h7F, 1'b0, 1'b1, 1'b0});
    p = ref_op(64'hFFFF_FFFF, 64'h1, 1'b1, 1'b0, 32);
    chk("model 32b wrap", {p.sum, p.c, p.o, p.z}, {32'h1, 1'b1, 1'b0, 1'b0});

    repeat (2) @(posedge Clock);
    #1;
    chk("reset out_valid", {31'd0, dov[0]}, 32'd0);
    chk("reset SUM", {24'd0, sum8}, 32'd0);
    chk("reset in_ready", {31'd0, dir[0]}, 32'd1);
    Reset = 1'b0;

    // 0xFF + 0x01 appears after exactly two edges
    step(1'b1, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b1);
    idle(1);
    chk("ff+1 early", {31'd0, dov[0]}, 32'd0);
    idle(1);
    chk("ff+1 valid", {31'd0, dov[0]}, 32'd1);
    chk("ff+1 result", {sum8, dc[0], dovf[0], dz[0]}, {8'h00, 1'b1, 1'b0, 1'b1});
    idle(1);

    step(1'b1, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h00, 32'h01, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h80, 32'h01, 1'b0, 1'b1, 1'b1);
    chk("7f+1 result", {sum8, dc[0], dovf[0], dz[0]}, {8'h80, 1'b0, 1'b1, 1'b0});
    idle(1);
    chk("0-1 result", {sum8, dc[0], dovf[0], dz[0]}, {8'hFF, 1'b1, 1'b0, 1'b0});
    idle(1);
    chk("80-1 result", {sum8, dc[0], dovf[0], dz[0]}, {8'h7F, 1'b0, 1'b1, 1'b0});
    idle(2);

    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      if (dov[0]) cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      idle(1);
      if (dov[0]) cnt++;
    end
    chk("stream16 count", cnt, 32'd16);
    idle(6);

    // fill the 8-bit pipe with the consumer stalled, then hold four cycles
    step(1'b1, 32'h10, 32'h20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h01, 32'h01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h02, 32'h02, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'h55, 32'h55, 1'b0, 1'b0, 1'b0);
      chk("stall in_ready", {31'd0, dir[0]}, 32'd0);
      chk("stall SUM", {24'd0, sum8}, 32'h30);
    end
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("release 1", {24'd0, sum8}, 32'h02);
    idle(1);
    chk("release 2", {24'd0, sum8}, 32'h04);
    idle(8);

    step(1'b1, 32'h03, 32'h04, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h05, 32'h06, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h07, 32'h08, 1'b0, 1'b0, 1'b1);
    chk("midstream valid", {31'd0, dov[0]}, 32'd1);
    in_valid = 1'b0;
    Reset    = 1'b1;
    #1;
    chk("async reset", {22'd0, dov[0], dir[0], sum8}, {22'd0, 1'b0, 1'b1, 8'h00});
    chk("async reset flags", {29'd0, dc[0], dovf[0], dz[0]}, 32'd0);
    chk("async reset d1", {31'd0, dov[1]}, 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    for (int i = 0; i < 6000; i++) begin
      step(($urandom_range(0, 3) != 0), pick(), pick(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
    end
    idle(10);
    for (int d = 0; d < 3; d++) chk($sformatf("d%0d drained", d), sbq[d].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
